div_share_arbiter: RTL and testbench

- Shares one shift/add divider (datapath plus its sequencing controller) between two requesters.
- Arbitrates requests round-robin and latches the winner's operands onto the datapath.
- Issues a one-cycle start and detects completion from the controller's valid.
- Returns quotient/remainder with a per-requester done pulse; a watchdog flags a hung operation.

---
 rtl/div_share_arbiter.sv | 128 ++++++++++++
 tb/tb_div_share_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin front end that time-shares one iterative divider between two requesters.
// Operands are latched at grant; results return with a per-requester done pulse or a timeout error.
module div_share_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             err,
    output logic             busy,
    output logic             dp_start,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    input  logic             dp_valid,
    input  logic [WIDTH-1:0] dp_quot,
    input  logic [WIDTH-1:0] dp_rem
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, DONE} state_t;

    state_t          state_reg, state_next;
    logic            last_reg;
    logic            owner_reg;
    logic            valid_q_reg;
    logic [CW-1:0]   count_reg;
    logic            grant_valid;
    logic            grant_id;
    logic            completion;
    logic            timed_out;

    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_id    = ~last_reg;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end

        // Only a fresh rising edge of valid counts; a level left over from the last op is ignored.
        completion = (state_reg == RUN) && dp_valid && !valid_q_reg;
        timed_out  = (state_reg == RUN) && (count_reg == CW'(TIMEOUT - 1));

        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = LAUNCH;
            LAUNCH:  state_next = RUN;
            RUN:     if (completion || timed_out) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            owner_reg   <= 1'b0;
            valid_q_reg <= 1'b0;
            count_reg   <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            dp_start    <= 1'b0;
            dp_a        <= '0;
            dp_b        <= '0;
        end else begin
            state_reg   <= state_next;
            valid_q_reg <= dp_valid;
            busy        <= (state_next != IDLE);
            dp_start    <= (state_reg == IDLE) && grant_valid;
            done0       <= 1'b0;
            done1       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_valid) begin
                        owner_reg <= grant_id;
                        dp_a      <= grant_id ? a1 : a0;
                        dp_b      <= grant_id ? b1 : b0;
                    end
                end
                LAUNCH: begin
                    count_reg <= '0;
                end
                RUN: begin
                    count_reg <= count_reg + 1'b1;
                    if (completion) begin
                        quot <= dp_quot;
                        rem  <= dp_rem;
                        err  <= 1'b0;
                    end else if (timed_out) begin
                        quot <= '0;
                        rem  <= '0;
                        err  <= 1'b1;
                    end
                end
                DONE: begin
                    // A requester that has walked away gets no pulse; the result is dropped.
                    done0    <= !owner_reg && req0;
                    done1    <= owner_reg && req1;
                    last_reg <= owner_reg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: behavioural divider model plus a scoreboard of expected results.
module tb_div_share_arbiter;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             req0 = 1'b0, req1 = 1'b0;
    logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic             done0, done1, err, busy, dp_start;
    logic [WIDTH-1:0] quot, rem, dp_a, dp_b;
    logic             dp_valid = 1'b0;
    logic [WIDTH-1:0] dp_quot = '0, dp_rem = '0;

    div_share_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .done0(done0), .done1(done1), .quot(quot), .rem(rem), .err(err), .busy(busy),
        .dp_start(dp_start), .dp_a(dp_a), .dp_b(dp_b),
        .dp_valid(dp_valid), .dp_quot(dp_quot), .dp_rem(dp_rem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             e;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   mode_lat = 9;       // cycles from dp_start to valid rise; negative = never
    bit   stale_mode = 1'b0;
    int   start_cyc = -1000;
    int   exp_done_cyc = -1;
    int   start_count = 0;
    bit   timed_out = 1'b0;
    logic [WIDTH-1:0] op_q = '0, op_r = '0;

    // Divider model and result monitor share one loop so their ordering per cycle is fixed.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (done0 || done1) begin
                exp_t e;
                int   got_id;
                got_id = done1 ? 1 : 0;
                if (done0 && done1) begin
                    total_cnt++;
                    $display("FAIL both_done: done0=%0b done1=%0b, required one-hot", done0, done1);
                end
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_done: id=%0d quot=%0d at cycle %0d, required no done", got_id, quot, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("done id=%0d quot=%0d rem=%0d err=%0b cycle=%0d", got_id, quot, rem, err, cyc);
                    total_cnt++;
                    if (got_id !== e.id) $display("FAIL done_id: got %0d, required %0d", got_id, e.id);
                    else pass_cnt++;
                    total_cnt++;
                    if (quot !== e.q) $display("FAIL quot: got %0d, required %0d", quot, e.q);
                    else pass_cnt++;
                    total_cnt++;
                    if (rem !== e.r) $display("FAIL rem: got %0d, required %0d", rem, e.r);
                    else pass_cnt++;
                    total_cnt++;
                    if (err !== e.e) $display("FAIL err: got %0b, required %0b", err, e.e);
                    else pass_cnt++;
                    total_cnt++;
                    if (cyc !== exp_done_cyc) $display("FAIL done_latency: got cycle %0d, required %0d", cyc, exp_done_cyc);
                    else pass_cnt++;
                end
            end
            if (dp_start === 1'b1) begin
                start_cyc = cyc;
                start_count++;
                op_q = (dp_b == 0) ? '1 : dp_a / dp_b;
                op_r = (dp_b == 0) ? dp_a : dp_a % dp_b;
                exp_done_cyc = (mode_lat < 0) ? cyc + TIMEOUT + 2 : cyc + mode_lat + 2;
                if (stale_mode) begin
                    dp_valid = 1'b1;
                    dp_quot  = 8'hEE;
                    dp_rem   = 8'hEE;
                end else begin
                    dp_valid = 1'b0;
                end
            end else begin
                if (stale_mode && cyc == start_cyc + 2) dp_valid = 1'b0;
                if (mode_lat >= 0 && cyc == start_cyc + mode_lat) begin
                    dp_valid = 1'b1;
                    dp_quot  = op_q;
                    dp_rem   = op_r;
                end
            end
        end
    end

    task automatic wait_done(input int limit);
        timed_out = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done0 || done1) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic wait_start(input int limit);
        timed_out = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (dp_start === 1'b1) return;
        end
        timed_out = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", busy); else pass_cnt++;
        total_cnt++;
        if (dp_start !== 1'b0) $display("FAIL reset_dp_start: got %0b, required 0", dp_start); else pass_cnt++;
        total_cnt++;
        if ({done0, done1} !== 2'b00) $display("FAIL reset_done: got %b, required 00", {done0, done1}); else pass_cnt++;
        total_cnt++;
        if ({quot, rem} !== '0) $display("FAIL reset_result: got %h, required 0", {quot, rem}); else pass_cnt++;
        total_cnt++;
        if (err !== 1'b0) $display("FAIL reset_err: got %0b, required 0", err); else pass_cnt++;
        total_cnt++;
        if ({dp_a, dp_b} !== '0) $display("FAIL reset_operands: got %h, required 0", {dp_a, dp_b}); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        int s0;
        mode_lat = 9;
        stale_mode = 1'b0;
        s0 = start_count;
        sb.push_back('{0, 8'd14, 8'd2, 1'b0});
        a0 = 8'd100; b0 = 8'd7; req0 = 1'b1;
        wait_start(10);
        total_cnt++;
        if (timed_out) $display("FAIL single_start: got no dp_start, required one"); else pass_cnt++;
        total_cnt++;
        if (dp_a !== 8'd100 || dp_b !== 8'd7) $display("FAIL single_operands: got %0d/%0d, required 100/7", dp_a, dp_b);
        else pass_cnt++;
        a0 = 8'd3; b0 = 8'd1;   // must not disturb the running op
        wait_done(40);
        req0 = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL single_done: got no done, required done0"); else pass_cnt++;
        total_cnt++;
        if (start_count - s0 !== 1) $display("FAIL single_start_count: got %0d, required 1", start_count - s0); else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, done0, done1} !== 3'b000) $display("FAIL single_after: got busy/done %b, required 000", {busy, done0, done1});
        else pass_cnt++;
    endtask

    task automatic test_simultaneous;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        mode_lat = 4;
        sb.push_back('{0, 8'd22, 8'd2, 1'b0});
        sb.push_back('{1, 8'd15, 8'd2, 1'b0});
        sb.push_back('{0, 8'd22, 8'd2, 1'b0});
        a0 = 8'd200; b0 = 8'd9; a1 = 8'd77; b1 = 8'd5;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_done(30);
            total_cnt++;
            if (timed_out) $display("FAIL simul_done%0d: got no done, required one", k); else pass_cnt++;
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0 || sb.size() != 0) $display("FAIL simul_end: got busy=%0b pending=%0d, required 0/0", busy, sb.size());
        else pass_cnt++;
    endtask

    task automatic test_stale;
        stale_mode = 1'b1;
        mode_lat = 5;
        sb.push_back('{0, 8'd8, 8'd2, 1'b0});
        a0 = 8'd50; b0 = 8'd6; req0 = 1'b1;
        wait_done(30);
        req0 = 1'b0;
        stale_mode = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL stale_done: got no done, required done0"); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        mode_lat = -1;
        sb.push_back('{0, 8'd0, 8'd0, 1'b1});
        a0 = 8'd99; b0 = 8'd3; req0 = 1'b1;
        wait_done(TIMEOUT + 20);
        req0 = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL timeout_done: got no done, required err done"); else pass_cnt++;
        @(negedge clk);
        mode_lat = 3;
        sb.push_back('{0, 8'd2, 8'd1, 1'b0});
        a0 = 8'd9; b0 = 8'd4; req0 = 1'b1;
        wait_done(30);
        req0 = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL timeout_recover: got no done, required done0"); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_drop;
        bit seen_idle;
        mode_lat = 12;
        a1 = 8'd30; b1 = 8'd4; req1 = 1'b1;
        wait_start(10);
        repeat (3) @(negedge clk);
        req1 = 1'b0;
        a0 = 8'd60; b0 = 8'd7; req0 = 1'b1;
        sb.push_back('{0, 8'd8, 8'd4, 1'b0});
        seen_idle = 1'b0;
        for (int i = 0; i < 30 && !seen_idle; i++) begin
            @(negedge clk);
            if (busy === 1'b0) seen_idle = 1'b1;
        end
        total_cnt++;
        if (!seen_idle) $display("FAIL drop_busy: got busy stuck 1, required return to 0"); else pass_cnt++;
        total_cnt++;
        if (done1 !== 1'b0) $display("FAIL drop_done1: got %0b, required 0", done1); else pass_cnt++;
        wait_done(40);
        req0 = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL drop_next: got no done, required done0"); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        mode_lat = 20;
        a0 = 8'd10; b0 = 8'd3; req0 = 1'b1;
        wait_start(10);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        total_cnt++;
        if ({busy, dp_start, done0, done1, err} !== 5'b0) $display("FAIL midreset_ctrl: got %b, required 00000", {busy, dp_start, done0, done1, err});
        else pass_cnt++;
        total_cnt++;
        if ({dp_a, dp_b, quot, rem} !== '0) $display("FAIL midreset_data: got %h, required 0", {dp_a, dp_b, quot, rem});
        else pass_cnt++;
        req0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (25) begin
            @(negedge clk);
            if (done0 || done1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL midreset_nodone: got %0d dones, required 0", dones); else pass_cnt++;
        mode_lat = 3;
        sb.push_back('{1, 8'd5, 8'd1, 1'b0});
        a1 = 8'd21; b1 = 8'd4; req1 = 1'b1;
        wait_done(30);
        req1 = 1'b0;
        total_cnt++;
        if (timed_out) $display("FAIL midreset_req1: got no done, required done1"); else pass_cnt++;
        @(negedge clk);
        sb.push_back('{0, 8'd3, 8'd2, 1'b0});
        sb.push_back('{1, 8'd5, 8'd0, 1'b0});
        a0 = 8'd17; b0 = 8'd5; a1 = 8'd40; b1 = 8'd8;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wait_done(30);
            total_cnt++;
            if (timed_out) $display("FAIL midreset_tie%0d: got no done, required one", k); else pass_cnt++;
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_stale();
        test_timeout();
        test_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
